// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on stall or flush, and saturating stall/flush event counters.
module id_ex_stage_register #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Flush,
   input  logic [4:0]            IF_ID_RegisterRs,
   input  logic [4:0]            IF_ID_RegisterRt,
   input  logic [4:0]            IF_ID_RegisterRd,
   input  logic                  ID_UsesRt,
   input  logic                  ID_RegWrite,
   input  logic                  ID_MemRead,
   input  logic                  ID_MemWrite,
   input  logic                  ID_MemtoReg,
   input  logic                  ID_ALUSrc,
   input  logic                  ID_RegDst,
   input  logic [3:0]            ID_ALUOp,
   input  logic [DATA_WIDTH-1:0] ID_ReadData1,
   input  logic [DATA_WIDTH-1:0] ID_ReadData2,
   input  logic [DATA_WIDTH-1:0] ID_Imm,
   output logic                  ID_EX_RegWrite,
   output logic                  ID_EX_MemRead,
   output logic                  ID_EX_MemWrite,
   output logic                  ID_EX_MemtoReg,
   output logic                  ID_EX_ALUSrc,
   output logic                  ID_EX_RegDst,
   output logic [3:0]            ID_EX_ALUOp,
   output logic [DATA_WIDTH-1:0] ID_EX_ReadData1,
   output logic [DATA_WIDTH-1:0] ID_EX_ReadData2,
   output logic [DATA_WIDTH-1:0] ID_EX_Imm,
   output logic [4:0]            ID_EX_RegisterRs,
   output logic [4:0]            ID_EX_RegisterRt,
   output logic [4:0]            ID_EX_RegisterRd,
   output logic                  PCWrite,
   output logic                  IF_ID_Write,
   output logic [CNT_WIDTH-1:0]  StallCount,
   output logic [CNT_WIDTH-1:0]  FlushCount
);

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  alu_src;
      logic                  reg_dst;
      logic [3:0]            alu_op;
      logic [DATA_WIDTH-1:0] rd1;
      logic [DATA_WIDTH-1:0] rd2;
      logic [DATA_WIDTH-1:0] imm;
      logic [4:0]            rs;
      logic [4:0]            rt;
      logic [4:0]            rd;
   } stage_t;

   stage_t               stage_q, stage_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                 hazard;
   logic                 stall;

   // Load-use detection against the load currently sitting in EX
   always_comb begin
      hazard = stage_q.mem_read && (stage_q.rt != 5'd0) &&
               ((stage_q.rt == IF_ID_RegisterRs) ||
                (ID_UsesRt && (stage_q.rt == IF_ID_RegisterRt)));
      stall  = hazard && !Flush;
   end

   // Next-state: flush bubble, then stall bubble, otherwise capture ID
   always_comb begin
      stage_d     = '{
         reg_write:  ID_RegWrite,
         mem_read:   ID_MemRead,
         mem_write:  ID_MemWrite,
         mem_to_reg: ID_MemtoReg,
         alu_src:    ID_ALUSrc,
         reg_dst:    ID_RegDst,
         alu_op:     ID_ALUOp,
         rd1:        ID_ReadData1,
         rd2:        ID_ReadData2,
         imm:        ID_Imm,
         rs:         IF_ID_RegisterRs,
         rt:         IF_ID_RegisterRt,
         rd:         IF_ID_RegisterRd
      };
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Flush) begin
         stage_d = '0;
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (stall) begin
         stage_d = '0;
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Pipeline register and counters, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stage_q     <= stage_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Output mapping
   always_comb begin
      ID_EX_RegWrite   = stage_q.reg_write;
      ID_EX_MemRead    = stage_q.mem_read;
      ID_EX_MemWrite   = stage_q.mem_write;
      ID_EX_MemtoReg   = stage_q.mem_to_reg;
      ID_EX_ALUSrc     = stage_q.alu_src;
      ID_EX_RegDst     = stage_q.reg_dst;
      ID_EX_ALUOp      = stage_q.alu_op;
      ID_EX_ReadData1  = stage_q.rd1;
      ID_EX_ReadData2  = stage_q.rd2;
      ID_EX_Imm        = stage_q.imm;
      ID_EX_RegisterRs = stage_q.rs;
      ID_EX_RegisterRt = stage_q.rt;
      ID_EX_RegisterRd = stage_q.rd;
      PCWrite          = !stall;
      IF_ID_Write      = !stall;
      StallCount       = stall_cnt_q;
      FlushCount       = flush_cnt_q;
   end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for id_ex_stage_register with a cycle-level reference model.
module tb_id_ex_stage_register;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic reset;
   logic Flush;
   logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd;
   logic ID_UsesRt, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
   logic [3:0] ID_ALUOp;
   logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
   logic ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_RegDst;
   logic [3:0] ID_EX_ALUOp;
   logic [DW-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
   logic [4:0] ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
   logic PCWrite, IF_ID_Write;
   logic [CW-1:0] StallCount, FlushCount;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage_register #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .Flush(Flush),
      .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
      .IF_ID_RegisterRd(IF_ID_RegisterRd), .ID_UsesRt(ID_UsesRt),
      .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
      .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
      .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
      .ID_Imm(ID_Imm),
      .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
      .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUOp(ID_EX_ALUOp),
      .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
      .ID_EX_Imm(ID_EX_Imm), .ID_EX_RegisterRs(ID_EX_RegisterRs),
      .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_RegisterRd(ID_EX_RegisterRd),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   // Reference model: the instruction record held in EX plus two event tallies
   typedef struct packed {
      logic rw, mr, mw, m2r, as, rdst;
      logic [3:0] op;
      logic [DW-1:0] d1, d2, imm;
      logic [4:0] rs, rt, rd;
   } rec_t;

   rec_t m_ex;
   int   m_stalls;
   int   m_flushes;

   function automatic rec_t id_rec();
      return '{ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
               ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm,
               IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd};
   endfunction

   function automatic rec_t dut_rec();
      return '{ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
               ID_EX_RegDst, ID_EX_ALUOp, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
               ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd};
   endfunction

   // Does the ID instruction need the value a load in EX has not produced yet?
   function automatic bit model_load_use();
      if (!m_ex.mr || m_ex.rt == 5'd0) return 1'b0;
      if (m_ex.rt == IF_ID_RegisterRs) return 1'b1;
      return ID_UsesRt && (m_ex.rt == IF_ID_RegisterRt);
   endfunction

   function automatic int sat(input int v);
      return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ex      <= '0;
         m_stalls  <= 0;
         m_flushes <= 0;
      end else if (Flush) begin
         m_ex      <= '0;
         m_flushes <= sat(m_flushes);
      end else if (model_load_use()) begin
         m_ex      <= '0;
         m_stalls  <= sat(m_stalls);
      end else begin
         m_ex      <= id_rec();
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      check("ex_record", 128'(dut_rec()), 128'(m_ex));
      check("stall_count", 128'(StallCount), 128'(m_stalls));
      check("flush_count", 128'(FlushCount), 128'(m_flushes));
      check("pc_write", 128'(PCWrite), 128'(!(model_load_use() && !Flush)));
      check("if_id_write", 128'(IF_ID_Write), 128'(!(model_load_use() && !Flush)));
   end

   task automatic clear_id();
      Flush = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0; IF_ID_RegisterRd = 0;
      ID_UsesRt = 0; ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemtoReg = 0;
      ID_ALUSrc = 0; ID_RegDst = 0; ID_ALUOp = 0;
      ID_ReadData1 = 0; ID_ReadData2 = 0; ID_Imm = 0;
   endtask

   task automatic load_word(input logic [4:0] rt, input logic [4:0] rs);
      clear_id();
      ID_MemRead = 1; ID_RegWrite = 1; ID_MemtoReg = 1; ID_ALUSrc = 1;
      IF_ID_RegisterRt = rt; IF_ID_RegisterRs = rs; ID_Imm = 32'h4;
   endtask

   task automatic add_op(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      clear_id();
      ID_RegWrite = 1; ID_RegDst = 1; ID_UsesRt = 1; ID_ALUOp = 4'h2;
      IF_ID_RegisterRd = rd; IF_ID_RegisterRs = rs; IF_ID_RegisterRt = rt;
      ID_ReadData1 = 32'hAAAA_0001; ID_ReadData2 = 32'h5555_0002;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1;
      clear_id();
      ID_RegWrite = 1; ID_ReadData1 = 32'h1234;
      step(); step();
      check("rst_regwrite", 128'(ID_EX_RegWrite), 128'd0);
      check("rst_rd1", 128'(ID_EX_ReadData1), 128'd0);
      check("rst_pcwrite", 128'(PCWrite), 128'd1);
      reset = 0;
      step();
      check("rel_regwrite", 128'(ID_EX_RegWrite), 128'd1);
      check("rel_rd1", 128'(ID_EX_ReadData1), 128'h1234);

      // lw $2 followed by add $4,$2,$3
      load_word(5'd2, 5'd1);
      step();
      add_op(5'd4, 5'd2, 5'd3);
      #1 check("lu_pcwrite", 128'(PCWrite), 128'd0);
      check("lu_ifid", 128'(IF_ID_Write), 128'd0);
      step();
      check("lu_bubble", 128'(ID_EX_RegWrite), 128'd0);
      check("lu_stalls", 128'(StallCount), 128'd1);
      check("lu_release", 128'(PCWrite), 128'd1);
      step();
      check("lu_add_rd", 128'(ID_EX_RegisterRd), 128'd4);
      check("lu_add_rd1", 128'(ID_EX_ReadData1), 128'hAAAA_0001);

      // lw $2 followed by sw $5,0($2): dependence through rs
      load_word(5'd2, 5'd0);
      step();
      clear_id();
      ID_MemWrite = 1; ID_ALUSrc = 1; ID_UsesRt = 1;
      IF_ID_RegisterRs = 5'd2; IF_ID_RegisterRt = 5'd5;
      #1 check("sw_pcwrite", 128'(PCWrite), 128'd0);
      step();
      check("sw_stalls", 128'(StallCount), 128'd2);
      step();
      check("sw_loaded", 128'(ID_EX_MemWrite), 128'd1);

      // lw $0 never stalls
      load_word(5'd0, 5'd3);
      step();
      add_op(5'd6, 5'd0, 5'd0);
      #1 check("r0_pcwrite", 128'(PCWrite), 128'd1);
      step();
      check("r0_stalls", 128'(StallCount), 128'd2);

      // Hazard and Flush together, from a clean reset
      reset = 1; #2 reset = 0;
      load_word(5'd2, 5'd0);
      step();
      add_op(5'd4, 5'd2, 5'd3);
      Flush = 1;
      #1 check("fl_pcwrite", 128'(PCWrite), 128'd1);
      step();
      Flush = 0;
      check("fl_flushes", 128'(FlushCount), 128'd1);
      check("fl_stalls", 128'(StallCount), 128'd0);
      check("fl_bubble", 128'(ID_EX_RegWrite), 128'd0);

      // lw $2,0($2) held in ID stalls every other cycle; push past 2^CW+3 stalls
      load_word(5'd2, 5'd2);
      for (int i = 0; i < 2 * ((1 << CW) + 3) + 2; i++) step();
      check("sat_stalls", 128'(StallCount), 128'hF);
      step(); step();
      check("sat_hold", 128'(StallCount), 128'hF);

      // Asynchronous reset mid-stall
      load_word(5'd2, 5'd0);
      step();
      add_op(5'd4, 5'd2, 5'd3);
      #1 check("ar_pre_stall", 128'(PCWrite), 128'd0);
      reset = 1;
      #1 check("ar_memread", 128'(ID_EX_MemRead), 128'd0);
      check("ar_pcwrite", 128'(PCWrite), 128'd1);
      check("ar_stalls", 128'(StallCount), 128'd0);
      reset = 0;
      step();
      check("ar_reload", 128'(ID_EX_RegisterRd), 128'd4);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
